// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music box playback controller.
package musicbox_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_PLAYING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_SWITCH  = 2'b11
  } state_t;

  localparam logic SONG_1 = 1'b0;
  localparam logic SONG_2 = 1'b1;

  localparam int ELAPSED_W = 12;

endpackage

// File: rtl/musicbox_play_ctrl_if.sv
// Request/control bundle between button conditioning (master) and the playback controller (slave).
interface musicbox_play_ctrl_if;
  import musicbox_pkg::*;

  logic   play_req;
  logic   song_req;
  logic   tick_1hz;
  logic   song_sel;
  logic   pause;
  logic   sec_tick;
  logic   cnt_clear;
  logic   song_done;
  state_t state;

  modport master (
    output play_req, song_req, tick_1hz,
    input  song_sel, pause, sec_tick, cnt_clear, song_done, state
  );

  modport slave (
    input  play_req, song_req, tick_1hz,
    output song_sel, pause, sec_tick, cnt_clear, song_done, state
  );
endinterface

// File: rtl/musicbox_elapsed.sv
// Elapsed-seconds register with per-song limit select and end-of-song compare.
module musicbox_elapsed
  import musicbox_pkg::*;
#(
  parameter int SONG1_LEN_S = 95,
  parameter int SONG2_LEN_S = 120
) (
  input  logic clk,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  input  logic song_sel,
  output logic at_end
);

  localparam logic [ELAPSED_W-1:0] LAST1 = ELAPSED_W'(SONG1_LEN_S - 1);
  localparam logic [ELAPSED_W-1:0] LAST2 = ELAPSED_W'(SONG2_LEN_S - 1);

  logic [ELAPSED_W-1:0] elapsed;
  logic [ELAPSED_W-1:0] last;

  assign last   = (song_sel == SONG_2) ? LAST2 : LAST1;
  assign at_end = (elapsed == last);

  // Clear wins over increment: the wrapping tick restarts the count at zero.
  always_ff @(posedge clk) begin
    if (RESET || clr) begin
      elapsed <= '0;
    end else if (inc) begin
      elapsed <= elapsed + ELAPSED_W'(1);
    end
  end

endmodule

// File: rtl/musicbox_play_ctrl.sv
// Play/pause/stop/switch controller for the music box.
// Optional feature: define MUSICBOX_AUTOPLAY_EN to alternate songs continuously at end-of-song.
module musicbox_play_ctrl
  import musicbox_pkg::*;
#(
  parameter int SONG1_LEN_S = 95,
  parameter int SONG2_LEN_S = 120
) (
  input logic                 clk,
  input logic                 RESET,
  musicbox_play_ctrl_if.slave bus
);

  if (SONG1_LEN_S < 1 || SONG1_LEN_S > 4095) begin : g_song1_len_err
    $error("SONG1_LEN_S must be within 1..4095");
  end
  if (SONG2_LEN_S < 1 || SONG2_LEN_S > 4095) begin : g_song2_len_err
    $error("SONG2_LEN_S must be within 1..4095");
  end

  state_t state_q, state_nxt;
  logic   song_sel_q, song_sel_nxt;
  logic   from_play_q, from_play_nxt;
  logic   cnt_clear_q, cnt_clear_nxt;
  logic   song_done_q, song_done_nxt;
  logic   tick_ok;
  logic   at_end;
  logic   el_clr;
  logic   el_inc;

  musicbox_elapsed #(
    .SONG1_LEN_S(SONG1_LEN_S),
    .SONG2_LEN_S(SONG2_LEN_S)
  ) u_elapsed (
    .clk     (clk),
    .RESET   (RESET),
    .clr     (el_clr),
    .inc     (el_inc),
    .song_sel(song_sel_q),
    .at_end  (at_end)
  );

  // A tick only counts when playing and no request claims the cycle.
  assign tick_ok = bus.tick_1hz && (state_q == ST_PLAYING) && !bus.play_req && !bus.song_req;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt     = state_q;
    song_sel_nxt  = song_sel_q;
    from_play_nxt = from_play_q;
    cnt_clear_nxt = 1'b0;
    song_done_nxt = 1'b0;
    el_clr        = 1'b0;
    el_inc        = 1'b0;
    case (state_q)
      ST_SWITCH: state_nxt = from_play_q ? ST_PLAYING : ST_STOPPED;
      default: begin
        if (bus.song_req) begin
          state_nxt     = ST_SWITCH;
          from_play_nxt = (state_q == ST_PLAYING);
          song_sel_nxt  = ~song_sel_q;
          cnt_clear_nxt = 1'b1;
          el_clr        = 1'b1;
        end else if (bus.play_req) begin
          state_nxt = (state_q == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
        end else if (tick_ok) begin
          if (at_end) begin
            el_clr        = 1'b1;
            cnt_clear_nxt = 1'b1;
            song_done_nxt = 1'b1;
`ifdef MUSICBOX_AUTOPLAY_EN
            song_sel_nxt  = ~song_sel_q;
`else
            state_nxt     = ST_STOPPED;
`endif
          end else begin
            el_inc = 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= ST_STOPPED;
      song_sel_q  <= SONG_1;
      from_play_q <= 1'b0;
      cnt_clear_q <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      song_sel_q  <= song_sel_nxt;
      from_play_q <= from_play_nxt;
      cnt_clear_q <= cnt_clear_nxt;
      song_done_q <= song_done_nxt;
    end
  end

  assign bus.state     = state_q;
  assign bus.song_sel  = song_sel_q;
  assign bus.pause     = (state_q != ST_PLAYING);
  assign bus.sec_tick  = tick_ok;
  assign bus.cnt_clear = cnt_clear_q;
  assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_musicbox_play_ctrl.sv
// Self-checking bench: a full-length and a short-song controller driven in lockstep against a reference model.
module tb_musicbox_play_ctrl;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  musicbox_play_ctrl_if m_if ();
  musicbox_play_ctrl_if s_if ();

  musicbox_play_ctrl #(.SONG1_LEN_S(95), .SONG2_LEN_S(120)) dut_main (
    .clk(clk), .RESET(RESET), .bus(m_if)
  );
  musicbox_play_ctrl #(.SONG1_LEN_S(3), .SONG2_LEN_S(5)) dut_small (
    .clk(clk), .RESET(RESET), .bus(s_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one slot per DUT, written from the playback rules.
  typedef enum {M_STOP, M_PLAY, M_PAUSE, M_SWITCH} mode_t;
  mode_t md_mode [2];
  bit    md_sel [2], md_from_play [2], md_clr [2], md_done [2];
  int    md_elapsed [2];
  int    len1 [2] = '{95, 3};
  int    len2 [2] = '{120, 5};
  bit    model_ok = 1'b0;

  function automatic logic [1:0] enc(input mode_t m);
    case (m)
      M_STOP:  return 2'd0;
      M_PLAY:  return 2'd1;
      M_PAUSE: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_step(input int i, input bit rst, play, song, tick);
    bit clr_n = 0, done_n = 0;
    if (rst) begin
      md_mode[i] = M_STOP; md_sel[i] = 0; md_elapsed[i] = 0; md_from_play[i] = 0;
    end else if (md_mode[i] == M_SWITCH) begin
      md_mode[i] = md_from_play[i] ? M_PLAY : M_STOP;
    end else if (song) begin
      md_from_play[i] = (md_mode[i] == M_PLAY);
      md_sel[i] = ~md_sel[i]; md_elapsed[i] = 0; clr_n = 1; md_mode[i] = M_SWITCH;
    end else if (play) begin
      md_mode[i] = (md_mode[i] == M_PLAY) ? M_PAUSE : M_PLAY;
    end else if (md_mode[i] == M_PLAY && tick) begin
      md_elapsed[i] = (md_elapsed[i] + 1) % (md_sel[i] ? len2[i] : len1[i]);
      if (md_elapsed[i] == 0) begin
        clr_n = 1; done_n = 1;
`ifdef MUSICBOX_AUTOPLAY_EN
        md_sel[i] = ~md_sel[i];
`else
        md_mode[i] = M_STOP;
`endif
      end
    end
    md_clr[i] = clr_n; md_done[i] = done_n;
  endtask

  task automatic cmp_inst(input string p, input int i, input bit play, song, tick,
                          input logic [1:0] st, input logic sel, pause, sec, clr, done,
                          input logic [11:0] el);
    check({p, ".state"},     16'(st),    16'(enc(md_mode[i])));
    check({p, ".song_sel"},  16'(sel),   16'(md_sel[i]));
    check({p, ".pause"},     16'(pause), 16'(md_mode[i] != M_PLAY));
    check({p, ".sec_tick"},  16'(sec),   16'(md_mode[i] == M_PLAY && tick && !play && !song));
    check({p, ".cnt_clear"}, 16'(clr),   16'(md_clr[i]));
    check({p, ".song_done"}, 16'(done),  16'(md_done[i]));
    check({p, ".elapsed"},   16'(el),    16'(md_elapsed[i]));
  endtask

  logic [1:0] obs_state;
  logic obs_sel, obs_pause, obs_sec, obs_clr, obs_done;
  int   sec_cnt = 0;

  // One clock: drive on negedge, compare before posedge, advance model, settle 1 after posedge.
  task automatic cycle(input bit rst, play, song, tick);
    @(negedge clk);
    RESET = rst;
    m_if.play_req = play; m_if.song_req = song; m_if.tick_1hz = tick;
    s_if.play_req = play; s_if.song_req = song; s_if.tick_1hz = tick;
    #1;
    obs_state = m_if.state; obs_sel = m_if.song_sel; obs_pause = m_if.pause;
    obs_sec = m_if.sec_tick; obs_clr = m_if.cnt_clear; obs_done = m_if.song_done;
    if (m_if.sec_tick === 1'b1) sec_cnt++;
    if (model_ok) begin
      cmp_inst("main", 0, play, song, tick, m_if.state, m_if.song_sel, m_if.pause,
               m_if.sec_tick, m_if.cnt_clear, m_if.song_done, dut_main.u_elapsed.elapsed);
      cmp_inst("small", 1, play, song, tick, s_if.state, s_if.song_sel, s_if.pause,
               s_if.sec_tick, s_if.cnt_clear, s_if.song_done, dut_small.u_elapsed.elapsed);
    end
    @(posedge clk);
    model_step(0, rst, play, song, tick);
    model_step(1, rst, play, song, tick);
    #1;
  endtask

  typedef struct {
    bit rst, play, song, tick;
    logic [1:0] st;
    bit sel, pause, sec, clr, done;
  } vec_t;

  vec_t vecs [18];

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},     16'(m_if.state),     16'd0);
    check({tag, ".pause"},     16'(m_if.pause),     16'd1);
    check({tag, ".song_sel"},  16'(m_if.song_sel),  16'd0);
    check({tag, ".sec_tick"},  16'(m_if.sec_tick),  16'd0);
    check({tag, ".cnt_clear"}, 16'(m_if.cnt_clear), 16'd0);
    check({tag, ".song_done"}, 16'(m_if.song_done), 16'd0);
    check({tag, ".elapsed"},   16'(dut_main.u_elapsed.elapsed), 16'd0);
  endtask

  initial begin
    //           rst play song tick  st    sel pause sec clr done
    vecs[0]  = '{0, 0, 0, 1, 2'd0, 0, 1, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 2'd1, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 2'd1, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 1, 2'd1, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 2'd2, 0, 1, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 2'd2, 0, 1, 0, 0, 0};
    vecs[7]  = '{0, 1, 1, 1, 2'd1, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 2'd3, 1, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 0, 1, 2'd1, 1, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 2'd1, 1, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 2'd3, 0, 1, 0, 1, 0};
    vecs[12] = '{0, 1, 0, 0, 2'd1, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 0, 2'd2, 0, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 2'd3, 1, 1, 0, 1, 0};
    vecs[15] = '{0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 0};
    vecs[16] = '{0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 1, 2'd1, 1, 0, 1, 0, 0};

    RESET = 1'b1;
    m_if.play_req = 0; m_if.song_req = 0; m_if.tick_1hz = 0;
    s_if.play_req = 0; s_if.song_req = 0; s_if.tick_1hz = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    model_ok = 1'b1;
    check_reset_vals("reset");

    // Idle with ticks: nothing moves
    sec_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1);
    check("idle.sec_cnt", 16'(sec_cnt), 16'd0);
    check_reset_vals("idle");

    // Table-driven vectors from a fresh reset
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].rst, vecs[i].play, vecs[i].song, vecs[i].tick);
      check($sformatf("vec%0d.state", i),     16'(obs_state), 16'(vecs[i].st));
      check($sformatf("vec%0d.song_sel", i),  16'(obs_sel),   16'(vecs[i].sel));
      check($sformatf("vec%0d.pause", i),     16'(obs_pause), 16'(vecs[i].pause));
      check($sformatf("vec%0d.sec_tick", i),  16'(obs_sec),   16'(vecs[i].sec));
      check($sformatf("vec%0d.cnt_clear", i), 16'(obs_clr),   16'(vecs[i].clr));
      check($sformatf("vec%0d.song_done", i), 16'(obs_done),  16'(vecs[i].done));
    end

    // Play 5 ticks, pause through 3 ticks, resume
    cycle(1, 0, 0, 0);
    sec_cnt = 0;
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check("pause.state", 16'(m_if.state), 16'd2);
    check("pause.elapsed", 16'(dut_main.u_elapsed.elapsed), 16'd5);
    cycle(0, 1, 0, 0);
    check("pause.sec_cnt", 16'(sec_cnt), 16'd5);
    check("resume.state", 16'(m_if.state), 16'd1);

    // Song switch while playing at elapsed=40
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1);
    check("sw40.elapsed_before", 16'(dut_main.u_elapsed.elapsed), 16'd40);
    cycle(0, 0, 1, 0);
    check("sw40.state", 16'(m_if.state), 16'd3);
    check("sw40.cnt_clear", 16'(m_if.cnt_clear), 16'd1);
    check("sw40.song_sel", 16'(m_if.song_sel), 16'd1);
    cycle(0, 0, 0, 0);
    check("sw40.after_state", 16'(m_if.state), 16'd1);
    check("sw40.after_clr", 16'(m_if.cnt_clear), 16'd0);
    check("sw40.after_elapsed", 16'(dut_main.u_elapsed.elapsed), 16'd0);

    // End-of-song on the short instance (song 1 = 3 s)
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("eos.done_early", 16'(s_if.song_done), 16'd0);
    cycle(0, 0, 0, 1);
    check("eos.song_done", 16'(s_if.song_done), 16'd1);
    check("eos.cnt_clear", 16'(s_if.cnt_clear), 16'd1);
`ifdef MUSICBOX_AUTOPLAY_EN
    check("eos.state", 16'(s_if.state), 16'd1);
    check("eos.song_sel", 16'(s_if.song_sel), 16'd1);
`else
    check("eos.state", 16'(s_if.state), 16'd0);
    check("eos.song_sel", 16'(s_if.song_sel), 16'd0);
`endif
    cycle(0, 0, 0, 0);
    check("eos.done_single", 16'(s_if.song_done), 16'd0);

    // play, song and tick together while playing
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 1);
    check("trio.sec_tick", 16'(obs_sec), 16'd0);
    check("trio.state", 16'(m_if.state), 16'd3);
    cycle(0, 0, 0, 0);
    check("trio.next_state", 16'(m_if.state), 16'd1);

    // Reset during SWITCH and during PAUSED
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    check("rst_sw.in_switch", 16'(m_if.state), 16'd3);
    cycle(1, 1, 1, 1);
    check_reset_vals("rst_sw");
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    check("rst_pause.in_paused", 16'(m_if.state), 16'd2);
    cycle(1, 1, 0, 1);
    check_reset_vals("rst_pause");

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(199) == 0, $urandom_range(11) == 0,
            $urandom_range(19) == 0, $urandom_range(1) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
